vxe_intr_coal: RTL and testbench

Interrupt coalescing controller placed between the VxE event sources (CU, vector processing units, memory unit) and `vxe_intr_unit`. It merges event bitmasks from several sources and accumulates them. It forwards one merged vector on the `vxe_intr_unit` CU-side valid/vector port when one of these fires: count threshold, timeout, urgent bit, or software flush. All thresholds and timeouts come from RegIO. With coalescing disabled it is a one-cycle registered merge.

---
 rtl/vxe_intr_coal_pkg.sv | 12 +
 rtl/vxe_intr_popcnt.sv | 17 +
 rtl/vxe_intr_coal.sv | 110 +++++++++++
 tb/tb_vxe_intr_coal.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vxe_intr_coal_pkg.sv
// Shared definitions for the VxE interrupt coalescer: FSM encodings and default widths.
package vxe_intr_coal_pkg;

  localparam int CW_DEF = 8;
  localparam int TW_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } coal_state_e;

endpackage

// File: rtl/vxe_intr_popcnt.sv
// Combinational popcount of the per-source valid bits; zero latency, no backpressure.
module vxe_intr_popcnt #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic [N-1:0]  vld,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(vld[i]);
    end
  end

endmodule

// File: rtl/vxe_intr_coal.sv
// Interrupt coalescer: merges source vectors, emits on threshold/timeout/urgent/flush.
// Registered output one cycle after the emit edge; events are never backpressured.
module vxe_intr_coal
  import vxe_intr_coal_pkg::*;
#(
  parameter int NR_SRC = 4,
  parameter int NR_INT = 4,
  parameter int CW     = CW_DEF,
  parameter int TW     = TW_DEF
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NR_SRC-1:0]        i_src_vld,
  input  logic [NR_SRC*NR_INT-1:0] i_src_intr,
  input  logic                     i_cfg_en,
  input  logic [CW-1:0]            i_cfg_thr,
  input  logic [TW-1:0]            i_cfg_tmo,
  input  logic [NR_INT-1:0]        i_cfg_urg,
  input  logic                     i_flush,
  output logic                     o_intr_vld,
  output logic [NR_INT-1:0]        o_intr,
  output logic [NR_INT-1:0]        o_pend,
  output logic                     o_busy
);

  coal_state_e       state, state_d;
  logic [NR_INT-1:0] acc, acc_d, acc_next, in_vec;
  logic [CW-1:0]     cnt, cnt_d, cnt_next, in_cnt;
  logic [CW:0]       cnt_sum;
  logic [TW-1:0]     tmr, tmr_d;
  logic [TW:0]       tmr_inc;
  logic              emit;

  vxe_intr_popcnt #(.N(NR_SRC), .CW(CW)) u_popcnt (
    .vld (i_src_vld),
    .cnt (in_cnt)
  );

  always_comb begin
    in_vec = '0;
    for (int k = 0; k < NR_SRC; k++) begin
      if (i_src_vld[k]) in_vec = in_vec | i_src_intr[k*NR_INT +: NR_INT];
    end
  end

  // Merge happens before the emit decision so events on the emit edge ride along.
  always_comb begin
    acc_next = ((state == ST_ACCUM) ? acc : '0) | in_vec;
    cnt_sum  = {1'b0, ((state == ST_ACCUM) ? cnt : '0)} + {1'b0, in_cnt};
    cnt_next = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    tmr_inc  = {1'b0, tmr} + {{TW{1'b0}}, 1'b1};
    emit = (!i_cfg_en && ((in_cnt != '0) || (acc != '0)))
        || ((cnt_next >= i_cfg_thr) && (cnt_next != '0))
        || ((acc_next & i_cfg_urg) != '0)
        || ((i_cfg_tmo != '0) && (state == ST_ACCUM) && (tmr_inc >= {1'b0, i_cfg_tmo}))
        || (i_flush && (acc_next != '0));
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    tmr_d   = tmr;
    if (emit) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      tmr_d   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_cnt != '0) begin
            state_d = ST_ACCUM;
            acc_d   = acc_next;
            cnt_d   = cnt_next;
            tmr_d   = '0;
          end
        end
        ST_ACCUM: begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          tmr_d = tmr_inc[TW] ? tmr : tmr_inc[TW-1:0];
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      cnt        <= '0;
      tmr        <= '0;
      o_intr_vld <= 1'b0;
      o_intr     <= '0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      cnt        <= cnt_d;
      tmr        <= tmr_d;
      o_intr_vld <= emit;
      if (emit) o_intr <= acc_next;
    end
  end

  assign o_pend = acc;
  assign o_busy = (state == ST_ACCUM);

endmodule

// File: tb/tb_vxe_intr_coal.sv
// Scoreboard bench for vxe_intr_coal: expected vectors queued at stimulus, popped on each pulse.
module tb_vxe_intr_coal;

  localparam int NR_SRC = 4;
  localparam int NR_INT = 4;
  localparam int CW     = 8;
  localparam int TW     = 16;

  logic                     clk;
  logic                     nrst;
  logic [NR_SRC-1:0]        i_src_vld;
  logic [NR_SRC*NR_INT-1:0] i_src_intr;
  logic                     i_cfg_en;
  logic [CW-1:0]            i_cfg_thr;
  logic [TW-1:0]            i_cfg_tmo;
  logic [NR_INT-1:0]        i_cfg_urg;
  logic                     i_flush;
  logic                     o_intr_vld;
  logic [NR_INT-1:0]        o_intr;
  logic [NR_INT-1:0]        o_pend;
  logic                     o_busy;

  int n_chk;
  int n_err;
  logic [NR_INT-1:0] sb[$];

  vxe_intr_coal #(.NR_SRC(NR_SRC), .NR_INT(NR_INT), .CW(CW), .TW(TW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_src_vld  (i_src_vld),
    .i_src_intr (i_src_intr),
    .i_cfg_en   (i_cfg_en),
    .i_cfg_thr  (i_cfg_thr),
    .i_cfg_tmo  (i_cfg_tmo),
    .i_cfg_urg  (i_cfg_urg),
    .i_flush    (i_flush),
    .o_intr_vld (o_intr_vld),
    .o_intr     (o_intr),
    .o_pend     (o_pend),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every pulse must match the oldest expected vector.
  always @(negedge clk) begin
    if (nrst && o_intr_vld) begin
      if (sb.size() == 0) chk("unexpected_pulse", {28'd0, o_intr}, 32'hdead);
      else                chk("sb_intr", {28'd0, o_intr}, {28'd0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [NR_INT-1:0] v);
    i_src_vld[k] = 1'b1;
    i_src_intr[k*NR_INT +: NR_INT] = v;
  endtask

  task automatic clr_src();
    i_src_vld  = '0;
    i_src_intr = '0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    nrst = 1'b0;
    clr_src();
    i_cfg_en = 1'b0; i_cfg_thr = 8'd3; i_cfg_tmo = '0; i_cfg_urg = '0; i_flush = 1'b0;
    tick(); tick();
    chk("rst_vld",  {31'd0, o_intr_vld}, 32'd0);
    chk("rst_intr", {28'd0, o_intr}, 32'd0);
    chk("rst_pend", {28'd0, o_pend}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    nrst = 1'b1;
    tick();

    // Bypass, including back-to-back pulses
    set_src(0, 4'b1010); sb.push_back(4'b1010);
    tick();
    chk("byp_vld",  {31'd0, o_intr_vld}, 32'd1);
    chk("byp_intr", {28'd0, o_intr}, 32'ha);
    chk("byp_busy", {31'd0, o_busy}, 32'd0);
    set_src(0, 4'b0010); sb.push_back(4'b0010);
    tick();
    chk("byp_b2b_vld",  {31'd0, o_intr_vld}, 32'd1);
    chk("byp_b2b_intr", {28'd0, o_intr}, 32'h2);
    clr_src();
    tick();
    chk("byp_idle_vld", {31'd0, o_intr_vld}, 32'd0);
    chk("intr_hold",    {28'd0, o_intr}, 32'h2);

    // Threshold 3 with single events
    i_cfg_en = 1'b1; i_cfg_thr = 8'd3;
    set_src(0, 4'b0001); tick();
    chk("thr_pend1", {28'd0, o_pend}, 32'h1);
    chk("thr_busy1", {31'd0, o_busy}, 32'd1);
    chk("thr_vld1",  {31'd0, o_intr_vld}, 32'd0);
    set_src(0, 4'b0100); tick();
    chk("thr_pend2", {28'd0, o_pend}, 32'h5);
    chk("thr_vld2",  {31'd0, o_intr_vld}, 32'd0);
    set_src(0, 4'b1000); sb.push_back(4'b1101); tick();
    chk("thr_vld3",  {31'd0, o_intr_vld}, 32'd1);
    chk("thr_intr3", {28'd0, o_intr}, 32'hd);
    chk("thr_pend3", {28'd0, o_pend}, 32'h0);
    chk("thr_busy3", {31'd0, o_busy}, 32'd0);
    clr_src(); tick();

    // Timeout 5
    i_cfg_thr = 8'd8; i_cfg_tmo = 16'd5;
    set_src(1, 4'b0010); tick();
    clr_src();
    chk("tmo_busy0", {31'd0, o_busy}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("tmo_wait_vld",  {31'd0, o_intr_vld}, 32'd0);
      chk("tmo_wait_busy", {31'd0, o_busy}, 32'd1);
    end
    sb.push_back(4'b0010);
    tick();
    chk("tmo_vld",  {31'd0, o_intr_vld}, 32'd1);
    chk("tmo_busy", {31'd0, o_busy}, 32'd0);
    i_cfg_tmo = '0;
    tick();

    // Urgent with two simultaneous sources
    i_cfg_urg = 4'b1000;
    set_src(0, 4'b0001); set_src(2, 4'b1000); sb.push_back(4'b1001);
    tick();
    chk("urg_vld",  {31'd0, o_intr_vld}, 32'd1);
    chk("urg_intr", {28'd0, o_intr}, 32'h9);
    clr_src(); i_cfg_urg = '0;

    // Events are counted, not bits: two sources reach thr=2, one wide vector does not
    i_cfg_thr = 8'd2;
    set_src(1, 4'b0001); set_src(3, 4'b0010); sb.push_back(4'b0011);
    tick();
    chk("cnt2_vld", {31'd0, o_intr_vld}, 32'd1);
    clr_src();
    set_src(0, 4'b0011); tick();
    chk("cnt1_vld",  {31'd0, o_intr_vld}, 32'd0);
    chk("cnt1_busy", {31'd0, o_busy}, 32'd1);
    clr_src(); i_flush = 1'b1; sb.push_back(4'b0011); tick();
    i_flush = 1'b0;
    chk("cnt1_flush_vld", {31'd0, o_intr_vld}, 32'd1);

    // Flush with pending and without pending
    i_cfg_thr = 8'd8;
    set_src(0, 4'b0100); tick(); clr_src();
    chk("fl_pend", {28'd0, o_pend}, 32'h4);
    i_flush = 1'b1; sb.push_back(4'b0100); tick();
    chk("fl_vld", {31'd0, o_intr_vld}, 32'd1);
    tick(); i_flush = 1'b0;
    chk("fl_empty_vld",  {31'd0, o_intr_vld}, 32'd0);
    chk("fl_empty_busy", {31'd0, o_busy}, 32'd0);

    // Clearing enable while accumulating
    set_src(2, 4'b0110); tick(); clr_src();
    chk("dis_busy", {31'd0, o_busy}, 32'd1);
    i_cfg_en = 1'b0; sb.push_back(4'b0110); tick();
    chk("dis_vld",  {31'd0, o_intr_vld}, 32'd1);
    chk("dis_intr", {28'd0, o_intr}, 32'h6);
    i_cfg_en = 1'b1;

    // thr=1 emits on arrival
    i_cfg_thr = 8'd1;
    set_src(3, 4'b0100); sb.push_back(4'b0100); tick(); clr_src();
    chk("thr1_vld", {31'd0, o_intr_vld}, 32'd1);
    i_cfg_thr = 8'd8;
    tick();

    // Reset mid-ACCUM discards pending bits
    set_src(1, 4'b0110); tick(); clr_src();
    chk("rst_mid_pend", {28'd0, o_pend}, 32'h6);
    nrst = 1'b0; #2;
    chk("rst_mid_pend0", {28'd0, o_pend}, 32'h0);
    chk("rst_mid_busy0", {31'd0, o_busy}, 32'd0);
    chk("rst_mid_intr0", {28'd0, o_intr}, 32'h0);
    chk("rst_mid_vld0",  {31'd0, o_intr_vld}, 32'd0);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_vld", {31'd0, o_intr_vld}, 32'd0);
    end

    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
